// File: rtl/pw_lockout_ctrl_if.sv
// Keypad-side signal bundle for pw_lockout_ctrl.
//   master : drives char_in/enter/relock and observes the status outputs.
//   slave  : the lock controller.
// Signals: char_in (character), enter (level button), relock (level),
//          open, wrong, locked_out, char_idx, fail_cnt (status).
interface pw_lockout_ctrl_if #(
  parameter int PW_WIDTH  = 8,
  parameter int PW_LEN    = 4,
  parameter int MAX_TRIES = 3
);
  localparam int IDX_W = (PW_LEN > 1) ? $clog2(PW_LEN) : 1;
  localparam int CNT_W = $clog2(MAX_TRIES + 1);

  logic [PW_WIDTH-1:0] char_in;
  logic                enter;
  logic                relock;
  logic                open;
  logic                wrong;
  logic                locked_out;
  logic [IDX_W-1:0]    char_idx;
  logic [CNT_W-1:0]    fail_cnt;

  modport master (
    output char_in, enter, relock,
    input  open, wrong, locked_out, char_idx, fail_cnt
  );

  modport slave (
    input  char_in, enter, relock,
    output open, wrong, locked_out, char_idx, fail_cnt
  );
endinterface

// File: rtl/pw_lockout_ctrl.sv
// Password lock with retry lockout.
// Characters are submitted on rising edges of enter; after PW_LEN characters
// the attempt either unlocks or counts as a failure. MAX_TRIES consecutive
// failures lock the keypad out for LOCKOUT_CYCLES clocks.
// Ports: clk, reset_n (async active-low), bus (pw_lockout_ctrl_if.slave).
//
// state   | meaning
// --------+--------------------------------------------------
// ENTRY   | collecting characters of an attempt
// UNLOCK  | password accepted, open=1 until relock
// LOCKOUT | too many failures, keypad ignored until timer ends
module pw_lockout_ctrl #(
  parameter int                         PW_WIDTH       = 8,
  parameter int                         PW_LEN         = 4,
  parameter logic [PW_WIDTH*PW_LEN-1:0] PASSWORD       = 32'h48454C4F,
  parameter int                         MAX_TRIES      = 3,
  parameter int                         LOCKOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pw_lockout_ctrl_if.slave     bus
);
  localparam int IDX_W = (PW_LEN > 1) ? $clog2(PW_LEN) : 1;
  localparam int CNT_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(LOCKOUT_CYCLES);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PW_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_FAIL = CNT_W'(MAX_TRIES - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {ENTRY, UNLOCK, LOCKOUT} state_t;

  state_t             state_q, state_d;
  logic               enter_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               mis_q, mis_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               wrong_q, wrong_d;

  logic [PW_WIDTH-1:0] exp_char;
  logic                accept;
  logic                char_bad;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ENTRY;
      // Resetting to 1 means a button held through reset needs a fresh press.
      enter_q <= 1'b1;
      idx_q   <= '0;
      mis_q   <= 1'b0;
      fail_q  <= '0;
      timer_q <= '0;
      wrong_q <= 1'b0;
    end else begin
      state_q <= state_d;
      enter_q <= bus.enter;
      idx_q   <= idx_d;
      mis_q   <= mis_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      wrong_q <= wrong_d;
    end
  end

  // First character lives in the most significant slice of PASSWORD.
  always_comb begin
    exp_char = '0;
    for (int i = 0; i < PW_LEN; i++) begin
      if (idx_q == IDX_W'(i))
        exp_char = PASSWORD[(PW_LEN-1-i)*PW_WIDTH +: PW_WIDTH];
    end
  end

  assign accept   = (state_q == ENTRY) && bus.enter && !enter_q && !bus.relock;
  assign char_bad = (bus.char_in != exp_char);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    wrong_d = wrong_q;
    case (state_q)
      ENTRY: begin
        if (bus.relock) begin
          idx_d = '0;
          mis_d = 1'b0;
        end else if (accept) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 1'b1;
            mis_d = mis_q | char_bad;
            if (idx_q == '0)
              wrong_d = 1'b0;
          end else begin
            idx_d = '0;
            mis_d = 1'b0;
            if (!(mis_q | char_bad)) begin
              state_d = UNLOCK;
              fail_d  = '0;
              wrong_d = 1'b0;
            end else begin
              wrong_d = 1'b1;
              fail_d  = fail_q + 1'b1;
              if (fail_q == LAST_FAIL) begin
                state_d = LOCKOUT;
                timer_d = TMR_LOAD;
              end
            end
          end
        end
      end
      UNLOCK: begin
        if (bus.relock) begin
          state_d = ENTRY;
          idx_d   = '0;
          mis_d   = 1'b0;
          fail_d  = '0;
        end
      end
      LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ENTRY;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  assign bus.open       = (state_q == UNLOCK);
  assign bus.locked_out = (state_q == LOCKOUT);
  assign bus.wrong      = wrong_q;
  assign bus.char_idx   = idx_q;
  assign bus.fail_cnt   = fail_q;
endmodule

// File: tb/tb_pw_lockout_ctrl.sv
module tb_pw_lockout_ctrl;
  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  pw_lockout_ctrl_if #(.PW_WIDTH(8), .PW_LEN(4), .MAX_TRIES(3)) bus ();

  pw_lockout_ctrl #(
    .PW_WIDTH(8), .PW_LEN(4), .PASSWORD(32'h48454C4F),
    .MAX_TRIES(3), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         is_relock;
    logic [7:0] ch;
    logic       exp_open;
    logic       exp_wrong;
    int         exp_idx;
    int         exp_fail;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Called one delta after a rising edge; leaves the bench at edge+1.
  task automatic press(input logic [7:0] c);
    bus.char_in = c;
    bus.enter   = 1'b1;
    @(posedge clk); #1;
    bus.enter   = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic relock_pulse();
    bus.relock = 1'b1;
    @(posedge clk); #1;
    bus.relock = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt;
    int k;

    //          relock ch     open wrong idx fail
    vecs[0]  = '{1'b0, 8'h48, 1'b0, 1'b0, 1, 0};
    vecs[1]  = '{1'b0, 8'h45, 1'b0, 1'b0, 2, 0};
    vecs[2]  = '{1'b0, 8'h4C, 1'b0, 1'b0, 3, 0};
    vecs[3]  = '{1'b0, 8'h4F, 1'b1, 1'b0, 0, 0};
    vecs[4]  = '{1'b1, 8'h00, 1'b0, 1'b0, 0, 0};
    vecs[5]  = '{1'b0, 8'h48, 1'b0, 1'b0, 1, 0};
    vecs[6]  = '{1'b0, 8'h45, 1'b0, 1'b0, 2, 0};
    vecs[7]  = '{1'b0, 8'h4C, 1'b0, 1'b0, 3, 0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1};
    vecs[9]  = '{1'b0, 8'h48, 1'b0, 1'b0, 1, 1};
    vecs[10] = '{1'b0, 8'h45, 1'b0, 1'b0, 2, 1};
    vecs[11] = '{1'b1, 8'h00, 1'b0, 1'b0, 0, 1};
    vecs[12] = '{1'b0, 8'h48, 1'b0, 1'b0, 1, 1};
    vecs[13] = '{1'b0, 8'h45, 1'b0, 1'b0, 2, 1};
    vecs[14] = '{1'b0, 8'h4C, 1'b0, 1'b0, 3, 1};
    vecs[15] = '{1'b0, 8'h4F, 1'b1, 1'b0, 0, 0};

    reset_n     = 1'b0;
    bus.char_in = 8'h00;
    bus.enter   = 1'b0;
    bus.relock  = 1'b0;
    #12;
    chk("rst_open",   int'(bus.open),       0);
    chk("rst_wrong",  int'(bus.wrong),      0);
    chk("rst_locked", int'(bus.locked_out), 0);
    chk("rst_idx",    int'(bus.char_idx),   0);
    chk("rst_fail",   int'(bus.fail_cnt),   0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].is_relock) relock_pulse();
      else                   press(vecs[i].ch);
      chk($sformatf("v%0d_open", i),   int'(bus.open),       int'(vecs[i].exp_open));
      chk($sformatf("v%0d_wrong", i),  int'(bus.wrong),      int'(vecs[i].exp_wrong));
      chk($sformatf("v%0d_locked", i), int'(bus.locked_out), 0);
      chk($sformatf("v%0d_idx", i),    int'(bus.char_idx),   vecs[i].exp_idx);
      chk($sformatf("v%0d_fail", i),   int'(bus.fail_cnt),   vecs[i].exp_fail);
    end

    // Three failed attempts, then count lockout cycles while hammering enter.
    relock_pulse();
    chk("lk_pre_open", int'(bus.open), 0);
    repeat (4) press(8'h00);
    chk("lk_fail1", int'(bus.fail_cnt), 1);
    repeat (4) press(8'h00);
    chk("lk_fail2", int'(bus.fail_cnt), 2);
    chk("lk_wrong2", int'(bus.wrong), 1);
    repeat (3) press(8'h00);
    bus.enter = 1'b1;
    @(posedge clk); #1;
    chk("lk_enter_locked", int'(bus.locked_out), 1);
    cnt = bus.locked_out ? 1 : 0;
    k = 0;
    while (bus.locked_out && k < 100) begin
      bus.enter = (k < 8) ? ~bus.enter : 1'b1;
      @(posedge clk); #1;
      k++;
      if (bus.locked_out) cnt++;
    end
    chk("lk_cycles",     cnt, 16);
    chk("lk_exit_state", int'(bus.locked_out), 0);
    chk("lk_exit_open",  int'(bus.open), 0);
    chk("lk_exit_fail",  int'(bus.fail_cnt), 0);
    chk("lk_exit_wrong", int'(bus.wrong), 1);
    chk("lk_exit_idx",   int'(bus.char_idx), 0);
    repeat (2) @(posedge clk); #1;
    chk("lk_held_enter_idx", int'(bus.char_idx), 0);
    bus.enter = 1'b0;
    @(posedge clk); #1;
    press(8'h48);
    chk("lk_after_idx",   int'(bus.char_idx), 1);
    chk("lk_after_wrong", int'(bus.wrong), 0);
    relock_pulse();

    // Relock beats a simultaneous enter edge in UNLOCK.
    press(8'h48); press(8'h45); press(8'h4C); press(8'h4F);
    chk("ul_open", int'(bus.open), 1);
    bus.relock  = 1'b1;
    bus.enter   = 1'b1;
    bus.char_in = 8'h48;
    @(posedge clk); #1;
    bus.relock = 1'b0;
    chk("ul_relock_open", int'(bus.open), 0);
    chk("ul_relock_idx",  int'(bus.char_idx), 0);
    @(posedge clk); #1;
    chk("ul_held_idx", int'(bus.char_idx), 0);

    // Enter held high through a reset pulse must not be accepted.
    #2 reset_n = 1'b0;
    #3 reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("rst_held_idx",  int'(bus.char_idx), 0);
    chk("rst_held_open", int'(bus.open), 0);
    bus.enter = 1'b0;
    @(posedge clk); #1;
    press(8'h48);
    chk("rst_new_edge_idx", int'(bus.char_idx), 1);

    // Async reset in the middle of a lockout.
    repeat (3) press(8'h00);
    chk("ar_fail1", int'(bus.fail_cnt), 1);
    repeat (8) press(8'h00);
    chk("ar_locked", int'(bus.locked_out), 1);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("ar_locked_async", int'(bus.locked_out), 0);
    chk("ar_fail_async",   int'(bus.fail_cnt), 0);
    chk("ar_wrong_async",  int'(bus.wrong), 0);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_after_locked", int'(bus.locked_out), 0);
    chk("ar_after_idx",    int'(bus.char_idx), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
